// File: rtl/risc8_datapath.sv
// ---------------------------------------------------------------------------
// risc8_datapath
//
// Register/ALU datapath of the 8-bit multicycle RISC. Sits directly below the
// phase controller: it consumes the controller's registered strobes and hands
// back the opcode and the accumulator-zero flag. Holds PC, IR, the operand
// register (OPR) and the accumulator (AC), and owns the single-port memory
// interface.
//
// Optional feature macro: RISC8_DP_CARRY_EN
//   defined   -> extra output `carry`, the carry-out of the last ADD loaded
//                into AC (cleared by any other ld_ac op, held while halted)
//   undefined -> no carry port or register; ADD wraps silently
//
// Parameters
//   DWIDTH  data/instruction width; opcode is always IR[DWIDTH-1:DWIDTH-3]
//   AWIDTH  address width; must satisfy AWIDTH <= DWIDTH-3
//   PC_RST  PC value after reset
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   sel        1: memory address from PC (when addr_mux=0)
//   rd, wr     memory strobes, passed to mem_rd/mem_wr unless halted
//   ld_ir      IR  <= mem_rdata
//   load       OPR <= mem_rdata
//   ld_ac      AC  <= ALU result
//   ld_pc      PC  <= IR address field (beats inc_pc)
//   inc_pc     PC  <= PC + 1 (wraps)
//   halt       set sticky halted state; same-cycle updates are dropped
//   data_e     drive AC onto mem_wdata
//   addr_mux   1: force memory address from IR address field
//   op_out     IR opcode to the controller
//   is_zero    AC == 0 (combinational)
//   mem_addr   memory address (combinational)
//   mem_rd     rd & ~halted
//   mem_wr     wr & ~halted
//   mem_wdata  data_e ? AC : 0
//   mem_rdata  memory read data
//   halted     sticky halt status (debug/state visibility)
//   pc_out     current PC (debug)
//   ac_out     current AC (debug)
//
// Strobe semantics: every control input is a level strobe sampled on the
// rising clk edge; there is no valid/ready handshake. A strobe acts for
// exactly the cycles it is high, and is ignored entirely once halted.
// ---------------------------------------------------------------------------
module risc8_datapath #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5,
  parameter int PC_RST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              rd,
  input  logic              ld_ir,
  input  logic              halt,
  input  logic              inc_pc,
  input  logic              ld_ac,
  input  logic              ld_pc,
  input  logic              wr,
  input  logic              data_e,
  input  logic              load,
  input  logic              addr_mux,
  output logic [2:0]        op_out,
  output logic              is_zero,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              halted,
  output logic [AWIDTH-1:0] pc_out,
  output logic [DWIDTH-1:0] ac_out
`ifdef RISC8_DP_CARRY_EN
  ,
  output logic              carry
`endif
);

  // Opcode encoding (IR top three bits)
  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [AWIDTH-1:0] PC_INIT = AWIDTH'(PC_RST);

  logic [AWIDTH-1:0] pc;
  logic [DWIDTH-1:0] ir;
  logic [DWIDTH-1:0] opr;
  logic [DWIDTH-1:0] ac;
  logic              halted_q;

  logic [AWIDTH-1:0] ir_addr;
  logic [DWIDTH-1:0] alu_add;
  logic [DWIDTH-1:0] alu_result;

  // A halt strobe and an already-halted core both freeze every register.
  logic              upd_en;

  assign upd_en  = ~halted_q & ~halt;
  assign ir_addr = ir[AWIDTH-1:0];
  assign op_out  = ir[DWIDTH-1:DWIDTH-3];
  assign is_zero = (ac == '0);
  assign halted  = halted_q;
  assign pc_out  = pc;
  assign ac_out  = ac;

  // addr_mux overrides sel; both select the IR address field.
  assign mem_addr  = (addr_mux || !sel) ? ir_addr : pc;
  assign mem_rd    = rd & ~halted_q;
  assign mem_wr    = wr & ~halted_q;
  // Write data is the current AC; a same-cycle ld_ac is not forwarded.
  assign mem_wdata = data_e ? ac : '0;

  // ---------------- ALU ----------------
  assign alu_add = ac + opr;

  always_comb begin
    alu_result = ac;
    unique case (op_out)
      OP_ADD:  alu_result = alu_add;
      OP_AND:  alu_result = ac & opr;
      OP_XOR:  alu_result = ac ^ opr;
      OP_LDA:  alu_result = opr;
      OP_HLT,
      OP_SKZ,
      OP_STO,
      OP_JMP:  alu_result = ac;
      default: alu_result = ac;
    endcase
  end

  // ---------------- Registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted_q <= 1'b0;
    end else if (halt) begin
      halted_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= PC_INIT;
    end else if (upd_en) begin
      if (ld_pc) begin
        pc <= ir_addr;
      end else if (inc_pc) begin
        pc <= pc + 1'b1;
      end
    end
  end

  // ld_ir and load together capture the same word into both registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir  <= '0;
      opr <= '0;
    end else if (upd_en) begin
      if (ld_ir) ir  <= mem_rdata;
      if (load)  opr <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ac <= '0;
    end else if (upd_en && ld_ac) begin
      ac <= alu_result;
    end
  end

`ifdef RISC8_DP_CARRY_EN
  // Carry-out of AC+OPR rebuilt from the operand MSBs and the sum MSB.
  logic add_cout;
  assign add_cout = (ac[DWIDTH-1] & opr[DWIDTH-1]) |
                    ((ac[DWIDTH-1] ^ opr[DWIDTH-1]) & ~alu_add[DWIDTH-1]);

  logic carry_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry_q <= 1'b0;
    end else if (upd_en && ld_ac) begin
      carry_q <= (op_out == OP_ADD) ? add_cout : 1'b0;
    end
  end
  assign carry = carry_q;
`endif

endmodule

// File: tb/tb_risc8_datapath.sv
// ---------------------------------------------------------------------------
// tb_risc8_datapath
//
// Directed bench for risc8_datapath: a table of ALU vectors applied in a loop,
// plus hand-written sequences for fetch/LDA, PC wrap and jump, store, halt and
// asynchronous reset. mem_rdata comes either from a small synchronous-read
// memory model or is driven directly by the bench.
// ---------------------------------------------------------------------------
module tb_risc8_datapath;

  localparam int DW = 8;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic sel = 0, rd = 0, ld_ir = 0, halt = 0, inc_pc = 0, ld_ac = 0;
  logic ld_pc = 0, wr = 0, data_e = 0, load = 0, addr_mux = 0;
  logic [2:0]    op_out;
  logic          is_zero, mem_rd, mem_wr, halted;
  logic [AW-1:0] mem_addr, pc_out;
  logic [DW-1:0] mem_wdata, mem_rdata, ac_out;
`ifdef RISC8_DP_CARRY_EN
  logic          carry;
`endif

  // Memory model: synchronous read, data valid the cycle after mem_rd.
  logic [DW-1:0] mem [0:31];
  logic [DW-1:0] mem_q = '0;
  logic [DW-1:0] rdata_drv = '0;
  logic          use_mem = 1'b0;
  always @(posedge clk) if (mem_rd) mem_q <= mem[mem_addr];
  assign mem_rdata = use_mem ? mem_q : rdata_drv;

  risc8_datapath #(.DWIDTH(DW), .AWIDTH(AW), .PC_RST(0)) dut (
    .clk(clk), .rst(rst), .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt),
    .inc_pc(inc_pc), .ld_ac(ld_ac), .ld_pc(ld_pc), .wr(wr), .data_e(data_e),
    .load(load), .addr_mux(addr_mux), .op_out(op_out), .is_zero(is_zero),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halted(halted),
    .pc_out(pc_out), .ac_out(ac_out)
`ifdef RISC8_DP_CARRY_EN
    , .carry(carry)
`endif
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Strobes are set just after a rising edge; cyc() runs one edge and clears them.
  task automatic cyc();
    @(posedge clk);
    #1;
    sel = 0; rd = 0; ld_ir = 0; halt = 0; inc_pc = 0; ld_ac = 0;
    ld_pc = 0; wr = 0; data_e = 0; load = 0; addr_mux = 0;
  endtask

  task automatic set_ir(input logic [DW-1:0] w);
    rdata_drv = w; ld_ir = 1; cyc();
  endtask

  task automatic set_opr(input logic [DW-1:0] w);
    rdata_drv = w; load = 1; cyc();
  endtask

  task automatic set_ac(input logic [DW-1:0] w);
    set_ir(8'hA0);      // LDA
    set_opr(w);
    ld_ac = 1; cyc();
  endtask

  task automatic set_pc(input logic [AW-1:0] a);
    set_ir({3'b111, a}); // JMP a
    ld_pc = 1; cyc();
  endtask

  // ---------------- ALU vector table ----------------
  typedef struct {
    logic [DW-1:0] instr;
    logic [DW-1:0] ac0;
    logic [DW-1:0] opr;
    logic [DW-1:0] exp_ac;
    logic          exp_zero;
    logic          exp_carry;
  } alu_vec_t;

  alu_vec_t vecs[10];

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //              instr   ac0    opr    exp_ac zero carry
    vecs[0] = '{8'h40, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1}; // ADD wraps
    vecs[1] = '{8'h45, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0}; // ADD
    vecs[2] = '{8'h5F, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1}; // ADD to zero
    vecs[3] = '{8'h60, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0}; // AND
    vecs[4] = '{8'h61, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0}; // AND to zero
    vecs[5] = '{8'h80, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0}; // XOR
    vecs[6] = '{8'h80, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0}; // XOR to zero
    vecs[7] = '{8'hA0, 8'h12, 8'h77, 8'h77, 1'b0, 1'b0}; // LDA
    vecs[8] = '{8'h20, 8'h33, 8'h44, 8'h33, 1'b0, 1'b0}; // SKZ: AC kept
    vecs[9] = '{8'hC0, 8'h09, 8'hFF, 8'h09, 1'b0, 1'b0}; // STO: AC kept

    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[0] = 8'hA3;
    mem[3] = 8'h80;

    // ---- reset state ----
    #12;
    chk("rst_pc", pc_out, 0);
    chk("rst_ac", ac_out, 0);
    chk("rst_op", op_out, 0);
    chk("rst_zero", is_zero, 1);
    chk("rst_halted", halted, 0);
    chk("rst_memwr", mem_wr, 0);
    chk("rst_wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;

    // ---- fetch / LDA 3 from memory ----
    use_mem = 1;
    sel = 1; rd = 1; cyc();
    sel = 1; rd = 1; ld_ir = 1; cyc();
    chk("lda_op", op_out, 3'd5);
    inc_pc = 1; cyc();
    rd = 1; sel = 0; #1;
    chk("lda_addr", mem_addr, 5'd3);
    cyc();
    rd = 1; load = 1; cyc();
    ld_ac = 1; cyc();
    chk("lda_ac", ac_out, 8'h80);
    chk("lda_pc", pc_out, 5'd1);
    chk("lda_zero", is_zero, 0);
    use_mem = 0;

    // ---- ALU table ----
    for (int i = 0; i < 10; i++) begin
      set_ac(vecs[i].ac0);
      set_opr(vecs[i].opr);
      set_ir(vecs[i].instr);
      ld_ac = 1; cyc();
      chk($sformatf("alu%0d_ac", i), ac_out, vecs[i].exp_ac);
      chk($sformatf("alu%0d_zero", i), is_zero, vecs[i].exp_zero);
`ifdef RISC8_DP_CARRY_EN
      chk($sformatf("alu%0d_carry", i), carry, vecs[i].exp_carry);
`endif
    end

    // ---- ADD wrap then AND to zero ----
    set_ac(8'hF0);
    set_opr(8'h20);
    set_ir(8'h40);
    ld_ac = 1; cyc();
    chk("add_wrap_ac", ac_out, 8'h10);
`ifdef RISC8_DP_CARRY_EN
    chk("add_wrap_carry", carry, 1);
`endif
    set_opr(8'h01);
    set_ir(8'h60);
    ld_ac = 1; cyc();
    chk("and_ac", ac_out, 8'h00);
    chk("and_zero", is_zero, 1);
`ifdef RISC8_DP_CARRY_EN
    chk("and_carry", carry, 0);
`endif

    // ---- ld_ir and load together ----
    rdata_drv = 8'h4B; ld_ir = 1; load = 1; cyc();
    chk("dual_op", op_out, 3'd2);
    set_ac(8'h00);   // rewrites IR to LDA, OPR to 0 -> reload OPR via dual path
    rdata_drv = 8'hA7; ld_ir = 1; load = 1; cyc();
    ld_ac = 1; cyc();
    chk("dual_ac", ac_out, 8'hA7);

    // ---- PC wrap and jump priority ----
    set_pc(5'd31);
    chk("pc_31", pc_out, 5'd31);
    inc_pc = 1; cyc();
    chk("pc_wrap", pc_out, 5'd0);
    set_ir(8'hE9);
    ld_pc = 1; inc_pc = 1; cyc();
    chk("pc_jmp", pc_out, 5'd9);

    // ---- STO ----
    set_ac(8'h3C);
    set_ir(8'hC4);
    addr_mux = 0; sel = 0; wr = 1; data_e = 1; #1;
    chk("sto_addr", mem_addr, 5'd4);
    chk("sto_wr", mem_wr, 1);
    chk("sto_wdata", mem_wdata, 8'h3C);
    data_e = 0; #1;
    chk("sto_wdata_off", mem_wdata, 8'h00);
    sel = 1; #1;
    chk("addr_pc", mem_addr, 5'd9);
    addr_mux = 1; #1;
    chk("addr_mux", mem_addr, 5'd4);
    // same-cycle ld_ac is not forwarded onto write data
    set_opr(8'h11);
    set_ir(8'hA4);
    data_e = 1; ld_ac = 1; #1;
    chk("wdata_pre", mem_wdata, 8'h3C);
    cyc();
    chk("wdata_post_ac", ac_out, 8'h11);
    chk("rd_no_effect_pre", pc_out, 5'd9);
    rd = 1; cyc();
    chk("rd_no_effect_ac", ac_out, 8'h11);
    chk("rd_no_effect_pc", pc_out, 5'd9);

    // ---- asynchronous reset mid-run ----
    set_ac(8'h5A);
    set_pc(5'd7);
    chk("pre_rst_ac", ac_out, 8'h5A);
    chk("pre_rst_pc", pc_out, 5'd7);
    #2 rst = 0; #1;
    chk("arst_ac", ac_out, 0);
    chk("arst_pc", pc_out, 0);
    chk("arst_zero", is_zero, 1);
    chk("arst_halted", halted, 0);
    chk("arst_memwr", mem_wr, 0);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;

    // ---- halt ----
    set_ac(8'h21);
    set_pc(5'd5);
    set_ir(8'h00);
    halt = 1; inc_pc = 1; ld_ac = 1; cyc();
    chk("halt_flag", halted, 1);
    chk("halt_pc", pc_out, 5'd5);
    chk("halt_ac", ac_out, 8'h21);
    set_opr(8'h99);
    ld_ac = 1; ld_pc = 1; wr = 1; rd = 1; #1;
    chk("halt_memwr", mem_wr, 0);
    chk("halt_memrd", mem_rd, 0);
    cyc();
    rdata_drv = 8'hE1; ld_ir = 1; cyc();
    ld_pc = 1; inc_pc = 1; ld_ac = 1; cyc();
    chk("halt_pc_hold", pc_out, 5'd5);
    chk("halt_ac_hold", ac_out, 8'h21);
    chk("halt_op_hold", op_out, 3'd0);
    chk("halt_sticky", halted, 1);
    #2 rst = 0; #1;
    chk("halt_rst", halted, 0);
    @(negedge clk);
    rst = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
